// File: rtl/sm3_digest_tx.sv
// sm3_digest_tx: buffers 256-bit SM3 digests and streams each as four 64-bit AXI-Stream beats, most significant first
// Ports: clk, rst_n (async active-low); digest_i/digest_valid_i digest strobe (no backpressure);
//    m_tdata_o/m_tkeep_o/m_tvalid_o/m_tlast_o/m_tready_i stream master; busy_o occupancy non-zero;
//    overflow_o/drop_cnt_o sticky drop flag and saturating drop count, cleared by ovf_clr_i
module sm3_digest_tx #(
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [255:0]  digest_i,
   input  logic          digest_valid_i,
   output logic [63:0]   m_tdata_o,
   output logic [7:0]    m_tkeep_o,
   output logic          m_tvalid_o,
   output logic          m_tlast_o,
   input  logic          m_tready_i,
   output logic          busy_o,
   output logic          overflow_o,
   output logic [7:0]    drop_cnt_o,
   input  logic          ovf_clr_i
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] SEND = 1'b1;
   logic [255:0]  mem_q [DEPTH];
   logic [255:0]  head;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [0:0]    state_q, state_d;
   logic [1:0]    beat_q, beat_d;
   logic          ovf_q, ovf_d;
   logic [7:0]    drop_q, drop_d;
   logic          hs, pop, full, push, drop;
   always_comb begin
      hs       = state_q == SEND && m_tready_i;
      pop      = hs && beat_q == 2'd3;
      full     = count_q == FULL_CNT;
      // a full buffer still accepts when the head frees its slot this very cycle
      push     = digest_valid_i && (!full || pop);
      drop     = digest_valid_i && full && !pop;
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d  = count_q + (AW+1)'(push) - (AW+1)'(pop);
      beat_d   = hs ? beat_q + 2'd1 : beat_q;
      state_d  = state_q == IDLE ? (count_q != '0 ? SEND : IDLE) : (pop && count_d == '0 ? IDLE : SEND);
      // a drop coinciding with a clear wins and restarts the count at one
      ovf_d    = drop || (ovf_q && !ovf_clr_i);
      drop_d   = drop ? (ovf_clr_i ? 8'd1 : (drop_q == 8'hFF ? drop_q : drop_q + 8'd1)) :
                 (ovf_clr_i ? 8'd0 : drop_q);
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= digest_i;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         state_q  <= IDLE;
         beat_q   <= '0;
         ovf_q    <= 1'b0;
         drop_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         state_q  <= state_d;
         beat_q   <= beat_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end
   // beat k takes bits [255-64k -: 64]; lower bound is 64*(3-k) = {~k, 6'b0}
   always_comb begin
      head       = mem_q[rd_ptr_q];
      m_tvalid_o = state_q == SEND;
      m_tkeep_o  = {8{m_tvalid_o}};
      m_tlast_o  = m_tvalid_o && beat_q == 2'd3;
      m_tdata_o  = m_tvalid_o ? head[{~beat_q, 6'b0} +: 64] : 64'h0;
      busy_o     = count_q != '0;
      overflow_o = ovf_q;
      drop_cnt_o = drop_q;
   end
endmodule

// File: doc/sm3_digest_tx.md
SM3_DIGEST_TX -- requirements
Module: sm3_digest_tx

Interface
REQ-001 The block SHALL have one parameter: DEPTH, default 2, number of 256-bit digests buffered (power of two, 2..16).
REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- digest_i  in  256  SM3 digest from the hash core.
- digest_valid_i  in  1  one-cycle strobe; digest_i is valid this cycle; no backpressure possible.
- m_tdata_o  out  64  output stream data beat.
- m_tkeep_o  out  8  byte enables; always 8'hFF while m_tvalid_o=1, 8'h00 otherwise.
- m_tvalid_o  out  1  beat valid.
- m_tlast_o  out  1  final (4th) beat of a digest.
- m_tready_i  in  1  downstream ready.
- busy_o  out  1  at least one digest buffered or in transit.
- overflow_o  out  1  sticky; a digest was dropped.
- drop_cnt_o  out  8  saturating count of dropped digests.
- ovf_clr_i  in  1  synchronous clear of overflow_o and drop_cnt_o.

Function
REQ-003 The block SHALL serialise each accepted digest into exactly 4 beats, most significant first: beat k carries digest[255-64k : 192-64k], k=0..3 (big-endian SM3 byte order preserved).
REQ-004 The block SHALL store accepted digests in a DEPTH-entry circular buffer with write pointer, read pointer and occupancy count of width log2(DEPTH)+1; pointers wrap from DEPTH-1 to 0.
REQ-005 A digest SHALL be written when digest_valid_i=1 and the buffer is not full, or when it is full but the head's last beat is handshaked (tvalid&tready&tlast) in the same cycle.
REQ-006 When digest_valid_i=1 and the buffer is full with no same-cycle pop, the digest SHALL be discarded, overflow_o set to 1 and drop_cnt_o incremented, saturating at 255.
REQ-007 ovf_clr_i=1 SHALL clear overflow_o and drop_cnt_o next cycle; a simultaneous drop takes priority (overflow_o=1, drop_cnt_o=1).
REQ-008 The transmit FSM SHALL have states IDLE and SEND with a 2-bit beat counter: IDLE->SEND when occupancy becomes non-zero; in SEND, each tvalid&tready increments the beat counter; on beat 3 handshake, counter returns to 0, entry popped, and FSM stays in SEND if occupancy after pop is non-zero, else returns to IDLE.
REQ-009 m_tvalid_o SHALL be 1 exactly when in SEND; m_tlast_o SHALL be 1 only when m_tvalid_o=1 and beat counter=3.
REQ-010 Latency: a digest strobed into an empty buffer at edge N SHALL present beat 0 with m_tvalid_o=1 after edge N+1 (one cycle), with no bubble between consecutive digests when m_tready_i is held 1.
REQ-011 While m_tvalid_o=1 and m_tready_i=0, m_tdata_o, m_tkeep_o, m_tlast_o SHALL hold stable; m_tvalid_o SHALL not deassert until handshake.
REQ-012 Sustained throughput SHALL be one beat per cycle; with m_tready_i=1 and DEPTH=2, one digest every 4 cycles is accepted indefinitely without drop.
REQ-013 m_tdata_o SHALL be 64'h0 when m_tvalid_o=0.
REQ-014 busy_o SHALL equal (occupancy != 0).

Reset
REQ-015 On rst_n=0, asynchronously: FSM=IDLE, pointers, occupancy, beat counter=0, m_tvalid_o=0, m_tlast_o=0, m_tkeep_o=0, m_tdata_o=0, busy_o=0, overflow_o=0, drop_cnt_o=0.
REQ-016 Reset asserted mid-digest SHALL abandon the partial digest; after release no beat of it is retransmitted and the first output is the next digest strobed.
REQ-017 Buffer contents need not be reset; only control state.

Verification
REQ-018 Single digest: digest_i=0x66C7F0F4...8F4BA8E0 (SM3("abc")), m_tready_i=1 -> 4 beats 0x66C7F0F462EEEDD9, 0xD1F2D46BDC10E4E2, 0x4167C4875CF2F7A2, 0x297DA02B8F4BA8E0; tlast on beat 4 only, tkeep=FF.
REQ-019 Backpressure: m_tready_i toggled 1,0,0,1 per cycle during a digest -> data stable during stalls, 4 beats total, no duplication.
REQ-020 Overflow, DEPTH=2, m_tready_i=0: 3 strobes -> first two buffered, third dropped, overflow_o=1, drop_cnt_o=1; release ready -> exactly 8 beats emitted; ovf_clr_i pulse -> both cleared.
REQ-021 Full-with-pop: buffer full, third strobe coincides with tlast handshake -> no drop, drop_cnt_o stays 0, 8 further beats follow.
REQ-022 Saturation: 300 dropped strobes -> drop_cnt_o=255.
REQ-023 Reset mid-stream after beat 2 -> all outputs 0 immediately; next digest streams from beat 0.
